// File: rtl/result_decoder.sv
// result_decoder: inverts the operation unit's 9-bit result back to an
// 8-bit operand, or flags the result as unreachable for the given op.
// Ops 00/01/10 resolve in one cycle. Op 11 (popcount) builds its minimal
// preimage one bit per cycle in a shift accumulator.
module result_decoder (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_result,
    input  logic [1:0] in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] acc_reg, acc_next;
    logic [3:0] count_reg, count_next;
    logic [7:0] data_reg, data_next;
    logic       error_reg, error_next;

    // Single-cycle inverse of the incoming request. Op 11 only reports its
    // error flag here; the operand itself comes from the serial path (r=0
    // and the error case both resolve to data 0).
    logic [7:0] inv_data;
    logic       inv_error;

    // Combinational inverse rules for each op code
    always_comb begin
        inv_data  = 8'h00;
        inv_error = 1'b0;
        case (in_op)
            2'b00: begin
                if (in_result[8]) inv_error = 1'b1;
                else              inv_data  = in_result[7:0];
            end
            2'b01: begin
                // Valid window 2..257; modulo-256 subtraction of the low
                // byte gives r-2 truncated to 8 bits across the whole window.
                if (in_result < 9'd2 || in_result > 9'd257) inv_error = 1'b1;
                else inv_data = in_result[7:0] - 8'd2;
            end
            2'b10: begin
                if (in_result[0]) inv_error = 1'b1;
                else              inv_data  = in_result[8:1];
            end
            default: begin
                if (in_result > 9'd8) inv_error = 1'b1;
            end
        endcase
    end

    // Next-state, accumulator and response-register logic
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        data_next  = data_reg;
        error_next = error_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (in_op == 2'b11 && !inv_error && in_result != 9'd0) begin
                        // Popcount r in 1..8: start with a single one and
                        // shift in r-1 more ones.
                        acc_next   = 8'h01;
                        count_next = in_result[3:0] - 4'd1;
                        if (in_result[3:0] == 4'd1) begin
                            data_next  = 8'h01;
                            error_next = 1'b0;
                            state_next = HOLD;
                        end else begin
                            state_next = SHIFT;
                        end
                    end else begin
                        data_next  = inv_data;
                        error_next = inv_error;
                        state_next = HOLD;
                    end
                end
            end
            SHIFT: begin
                acc_next   = {acc_reg[6:0], 1'b1};
                count_next = count_reg - 4'd1;
                // The output register is only written on the edge entering HOLD
                if (count_reg == 4'd1) begin
                    data_next  = {acc_reg[6:0], 1'b1};
                    error_next = 1'b0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            acc_reg   <= 8'h00;
            count_reg <= 4'd0;
            data_reg  <= 8'h00;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            data_reg  <= data_next;
            error_reg <= error_next;
        end
    end

    // Handshake flags are decoded from the state register alone
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == HOLD);
    assign out_data  = data_reg;
    assign out_error = error_reg;

endmodule

// File: tb/tb_result_decoder.sv
// Directed and randomized self-checking bench for result_decoder.
module tb_result_decoder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_result;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_error;

    int n_checks = 0;
    int n_fails  = 0;

    result_decoder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_error (out_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference inverse rules
    function automatic void model(input logic [1:0] op, input logic [8:0] r,
                                  output logic [7:0] d, output logic e, output int lat);
        d = 8'h00;
        e = 1'b0;
        lat = 1;
        case (op)
            2'd0: if (r > 9'd255) e = 1'b1; else d = r[7:0];
            2'd1: if (r < 9'd2 || r > 9'd257) e = 1'b1; else d = 8'(int'(r) - 2);
            2'd2: if (r[0]) e = 1'b1; else d = 8'(int'(r) / 2);
            default: begin
                if (r > 9'd8) e = 1'b1;
                else begin
                    for (int i = 0; i < int'(r); i++) d[i] = 1'b1;
                    if (r >= 9'd2) lat = int'(r);
                end
            end
        endcase
    endfunction

    // Forward operation of the operation unit
    function automatic logic [8:0] fwd(input logic [1:0] op, input logic [7:0] d);
        case (op)
            2'd0:    return {1'b0, d};
            2'd1:    return {1'b0, d} + 9'd2;
            2'd2:    return {d, 1'b0};
            default: return 9'($countones(d));
        endcase
    endfunction

    // Issue one request with out_ready held high and check timing and response
    task automatic do_req(input string tag, input logic [1:0] op, input logic [8:0] r,
                          input logic [7:0] exp_d, input logic exp_e, input int exp_lat);
        in_op     = op;
        in_result = r;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int k = 1; k < exp_lat; k++) begin
            chk({tag, "/busy_valid"}, 16'(out_valid), 16'd0);
            chk({tag, "/busy_ready"}, 16'(in_ready), 16'd0);
            tick();
        end
        chk({tag, "/valid"}, 16'(out_valid), 16'd1);
        chk({tag, "/data"}, 16'(out_data), 16'(exp_d));
        chk({tag, "/error"}, 16'(out_error), 16'(exp_e));
        chk({tag, "/hold_ready"}, 16'(in_ready), 16'd0);
        tick();
        chk({tag, "/done_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "/done_ready"}, 16'(in_ready), 16'd1);
        chk({tag, "/kept_data"}, 16'(out_data), 16'(exp_d));
        $display("req %s op=%0d r=%0d data=%02h err=%0d", tag, op, r, out_data, out_error);
    endtask

    initial begin
        logic [7:0] md;
        logic       me;
        int         ml;
        int         lat;
        int         hold_cycles;
        logic [1:0] rop;
        logic [8:0] rr;

        in_valid  = 1'b0;
        in_result = 9'd0;
        in_op     = 2'd0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("reset_ready", 16'(in_ready), 16'd1);
        chk("reset_valid", 16'(out_valid), 16'd0);
        chk("reset_data", 16'(out_data), 16'd0);
        chk("reset_error", 16'(out_error), 16'd0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();

        // Single-cycle ops
        do_req("op0_a5", 2'd0, 9'h0A5, 8'hA5, 1'b0, 1);
        do_req("op0_err", 2'd0, 9'h100, 8'h00, 1'b1, 1);
        do_req("op1_r1", 2'd1, 9'd1, 8'h00, 1'b1, 1);
        do_req("op1_r2", 2'd1, 9'd2, 8'h00, 1'b0, 1);
        do_req("op1_r257", 2'd1, 9'd257, 8'hFF, 1'b0, 1);
        do_req("op1_r258", 2'd1, 9'd258, 8'h00, 1'b1, 1);
        do_req("op2_1fe", 2'd2, 9'h1FE, 8'hFF, 1'b0, 1);
        do_req("op2_003", 2'd2, 9'h003, 8'h00, 1'b1, 1);
        // Popcount, serial path
        do_req("op3_r5", 2'd3, 9'd5, 8'h1F, 1'b0, 5);
        do_req("op3_r0", 2'd3, 9'd0, 8'h00, 1'b0, 1);
        do_req("op3_r1", 2'd3, 9'd1, 8'h01, 1'b0, 1);
        do_req("op3_r2", 2'd3, 9'd2, 8'h03, 1'b0, 2);
        do_req("op3_r8", 2'd3, 9'd8, 8'hFF, 1'b0, 8);
        do_req("op3_r9", 2'd3, 9'd9, 8'h00, 1'b1, 1);

        // Backpressure: second request must wait until the first drains
        in_op = 2'd0; in_result = 9'h033; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_result = 9'h044;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 16'(out_valid), 16'd1);
            chk("bp_data", 16'(out_data), 16'h33);
            chk("bp_error", 16'(out_error), 16'd0);
            chk("bp_ready", 16'(in_ready), 16'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle_valid", 16'(out_valid), 16'd0);
        chk("bp_idle_ready", 16'(in_ready), 16'd1);
        tick();
        chk("bp_second_valid", 16'(out_valid), 16'd1);
        chk("bp_second_data", 16'(out_data), 16'h44);
        in_valid = 1'b0;
        tick();
        chk("bp_second_done", 16'(out_valid), 16'd0);
        $display("req backpressure data=%02h", out_data);

        // Reset in the middle of a popcount shift
        in_op = 2'd3; in_result = 9'd7; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 16'(in_ready), 16'd1);
        chk("midrst_valid", 16'(out_valid), 16'd0);
        chk("midrst_data", 16'(out_data), 16'd0);
        chk("midrst_error", 16'(out_error), 16'd0);
        #10 reset_n = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("midrst_quiet", 16'(out_valid), 16'd0);
            tick();
        end
        $display("req mid-shift reset dropped");
        do_req("after_rst", 2'd1, 9'd100, 8'd98, 1'b0, 1);

        // Randomized requests with random out_ready against the reference model
        for (int n = 0; n < 2000; n++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'd3) rr = 9'($urandom_range(0, 12));
            else             rr = 9'($urandom_range(0, 511));
            model(rop, rr, md, me, ml);
            in_op = rop; in_result = rr; in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            chk("rnd_latency", 16'(lat), 16'(ml));
            chk("rnd_valid", 16'(out_valid), 16'd1);
            chk("rnd_data", 16'(out_data), 16'(md));
            chk("rnd_error", 16'(out_error), 16'(me));
            if (!me) chk("rnd_forward", 16'(fwd(rop, out_data)), 16'(rr));
            hold_cycles = $urandom_range(0, 2);
            out_ready = 1'b0;
            for (int k = 0; k < hold_cycles; k++) begin
                tick();
                chk("rnd_stable", 16'({out_valid, out_error, out_data}), 16'({1'b1, me, md}));
            end
            out_ready = 1'b1;
            tick();
            chk("rnd_release", 16'({out_valid, in_ready}), 16'b01);
            $display("rnd %0d op=%0d r=%0d data=%02h err=%0d lat=%0d", n, rop, rr, md, me, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/result_decoder.md
# result_decoder

Inverse stage for the 8-bit operation unit's 9-bit result stream. It accepts a 9-bit result and the 2-bit op code that produced it through a valid/ready handshake. For each result it recovers an 8-bit operand that the op maps to that result, or flags the result as unreachable. Ops 00/01/10 resolve in one cycle; op 11 (popcount) rebuilds its minimal preimage serially, one bit per cycle. The block sits on the verification/loopback path downstream of the operation unit.

## Interface
- No parameters; all widths are fixed.
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_result/in_op hold a request
- in_ready  output  1  block can accept a request; high exactly in IDLE
- in_result  input  9  result value to invert
- in_op  input  2  op code that produced in_result
- out_valid  output  1  out_data/out_error hold a response
- out_ready  input  1  downstream consumes the response
- out_data  output  8  recovered operand; 0 when out_error=1
- out_error  output  1  in_result is not reachable by in_op from any 8-bit operand

## Operation
- **States:** IDLE, SHIFT, HOLD.
- **Accept:** a request is accepted on a rising edge with in_valid=1 and in_ready=1. in_result and in_op are sampled only at that edge.
- **Inverse rules** (all unsigned; r = in_result):
  - op 00: r[8]=0 → data r[7:0]; otherwise error.
  - op 01: 2 ≤ r ≤ 257 → data r−2, truncated to 8 bits; otherwise error.
  - op 10: r[0]=0 → data r[8:1]; otherwise error. Every even 9-bit value is reachable.
  - op 11: r ≤ 8 → data is the minimal operand with r ones, i.e. (1<<r)−1, so r=8 gives 8'hFF; r > 8 → error.
- **IDLE accept, op 00/01/10, op 11 with error, or op 11 with r=0:** load out_data/out_error; go to HOLD.
- **IDLE accept, op 11 with 1 ≤ r ≤ 8:** set acc=8'h01 and count=r−1.
  - If count=0, go directly to HOLD with out_data=acc.
  - Otherwise go to SHIFT.
- **SHIFT:** on each edge, acc ← {acc[6:0],1'b1} and count ← count−1. On the edge where count goes 1→0, out_data takes the new acc and the state goes to HOLD.
- **SHIFT internals:** a 4-bit count is sufficient. out_data is not updated during SHIFT; it changes only on the edge that enters HOLD.
- **HOLD:** out_valid=1. out_data and out_error are stable until the handshake completes. On an edge with out_ready=1, go to IDLE and clear out_valid. out_data keeps its last value in IDLE.
- **No overlap:** the block holds one request at a time. in_ready=0 throughout SHIFT and HOLD, including the cycle in which out_ready is high.
- **in_valid while busy:** the request is ignored; the upstream stage must hold it.

## Timing
- **Reset** (asynchronous assert, synchronous-safe deassert):
  - state = IDLE, out_valid=0, out_data=8'h00, out_error=0, acc=0, count=0.
  - in_ready=1 immediately, because it is decoded from state.
- **Reset mid-SHIFT or mid-HOLD:** the in-flight request is dropped with no response.
- **Latency:** accept edge E0 → out_valid high after edge E0+L.
  - L = 1 for op 00/01/10, any error, and op 11 with r ∈ {0,1}.
  - L = r for op 11 with 2 ≤ r ≤ 8.
- **Throughput:** with out_ready held at 1, the HOLD→IDLE edge and the IDLE accept edge are distinct. Single-cycle ops therefore sustain one request per 2 cycles, and op 11 one request per L+1 cycles.
- **out_ready while out_valid=0:** ignored.
- **in_ready:** combinational from the state register only; it never depends on in_valid or out_ready.

## Test plan
- Reset, then op=00 with r=9'h0A5, out_ready=1 → out_valid after 1 edge with data=8'hA5, err=0. in_ready=0 that cycle, 1 the next.
- op=01, r ∈ {1, 2, 257, 258} → {err, data 0, data 255, err}. op=10, r ∈ {9'h1FE, 9'h003} → {data 8'hFF, err}.
- op=11, r=5 → in_ready low for 5 cycles; out_valid after edge E0+5 with data=8'h1F. Further cases:
  - r=0 → data 8'h00, L=1.
  - r=8 → data 8'hFF, L=8.
  - r=9 → err with L=1.
- Backpressure: hold out_ready=0 for 4 cycles in HOLD while in_valid=1 with a new request → data/err stable and second request not accepted. Raise out_ready → IDLE next edge; second request accepted on the following edge.
- Assert reset_n=0 mid-SHIFT for op=11, r=7 → outputs clear immediately; no out_valid afterwards; next request processed normally.
- Random 2000 requests with random out_ready → each response matches a scoreboard applying the inverse rules. For each non-error response, reapplying the forward op to out_data reproduces r.
